// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The stream opens with a 16-bit big-endian word count followed by 4 bytes per word.
package imem_loader_pkg;

  localparam int CNT_W = 16;
  localparam int LANES = 4;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // The announced count may equal the memory depth but must not exceed it.
  function automatic logic count_too_big(input logic [CNT_W-1:0] n, input int addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return {16'd0, n} > depth;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian 8->32 bit word assembler with a 2-bit byte-lane counter.
// word already includes the byte presented this cycle, so the top can write it on lane 3.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        last_lane
);

  logic [23:0] sreg;
  logic [1:0]  lane;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sreg <= '0;
      lane <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[15:0], data_byte};
      lane <= lane + 2'd1;
    end
  end

  assign word      = {sreg, data_byte};
  assign last_lane = (lane == 2'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program into instruction memory while holding the CPU in reset,
// then releases it once the announced number of words has been written.
//
// state    | meaning
// S_CNT_HI | waiting for word-count high byte
// S_CNT_LO | waiting for word-count low byte; decides done / error / data
// S_DATA   | assembling and writing words
// S_DONE   | load complete; CPU released once the final write has retired
// S_ERR    | announced count exceeds memory depth; stuck until reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic [CNT_W-1:0] count_full;
  logic [ADDR_W:0]  word_cnt_inc;
  logic [31:0]      asm_word;
  logic             asm_last;
  logic             asm_clear;
  logic             asm_shift;

  assign in_ready     = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DATA);
  assign xfer         = in_valid && in_ready;
  assign count_full   = {count[15:8], in_data};
  assign word_cnt_inc = word_cnt + 1'b1;
  assign asm_clear    = xfer && (state == S_CNT_LO);
  assign asm_shift    = xfer && (state == S_DATA);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .data_byte (in_data),
    .word      (asm_word),
    .last_lane (asm_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CNT_HI;
      count      <= '0;
      cpu_reset  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_CNT_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            state       <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
            if (count_full == '0) begin
              state <= S_DONE;
            end else if (count_too_big(count_full, ADDR_W)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer && asm_last) begin
            imem_we    <= 1'b1;
            imem_wdata <= asm_word;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            word_cnt   <= word_cnt_inc;
            if (CNT_W'(word_cnt_inc) == count) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Hold the CPU until the final write strobe has cleared.
          if (!imem_we) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end
        end
        S_ERR: begin
          err       <= 1'b1;
          cpu_reset <= 1'b1;
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: reset, normal loads, N=0, overflow,
// handshake gaps, mid-load abort and a full-depth load.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = -1;
  int rel_cyc = -1;
  bit done_seen = 0;
  bit rel_seen = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (!reset && done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    if (!reset && !cpu_reset && !rel_seen) begin
      rel_seen = 1;
      rel_cyc  = cyc;
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
    done_seen = 0;
    rel_seen  = 0;
    done_cyc  = -1;
    rel_cyc   = -1;
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      nchk++;
      $display("FAIL byte_accept: byte %h not accepted within 20 cycles (in_ready=%b)", b, in_ready);
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input int max_gap);
    int g;
    foreach (bytes[i]) begin
      if (max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        repeat (g) @(negedge clk);
      end
      send_byte(bytes[i]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); else npass++;
    nchk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else npass++;
    nchk++; if (imem_we !== 1'b0) $display("FAIL rst_imem_we: got %b want 0", imem_we); else npass++;
    nchk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_done_err: got done=%b err=%b want 0 0", done, err); else npass++;
    nchk++; if (word_cnt !== 9'd0) $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); else npass++;
    nchk++; if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) $display("FAIL rst_addr_data: got %h %h want 00 00000000", imem_addr, imem_wdata); else npass++;
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    do_reset();
    send_seq(s, 0);
    nchk++; if (cpu_reset !== 1'b1) $display("FAIL basic_hold_1: cpu_reset=%b one edge after last byte, want 1", cpu_reset); else npass++;
    repeat (4) @(negedge clk);
    nchk++; if (wa_q.size() !== 2) $display("FAIL basic_nwrites: got %0d want 2", wa_q.size()); else npass++;
    if (wa_q.size() == 2) begin
      nchk++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h12345678) $display("FAIL basic_w0: got %h %h want 00 12345678", wa_q[0], wd_q[0]); else npass++;
      nchk++; if (wa_q[1] !== 8'h01 || wd_q[1] !== 32'hABCDEF01) $display("FAIL basic_w1: got %h %h want 01 abcdef01", wa_q[1], wd_q[1]); else npass++;
    end
    nchk++; if (word_cnt !== 9'd2) $display("FAIL basic_word_cnt: got %0d want 2", word_cnt); else npass++;
    nchk++; if (done_cyc !== acc_cyc + 2) $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc, acc_cyc + 2); else npass++;
    nchk++; if (rel_cyc !== acc_cyc + 2) $display("FAIL basic_release_time: got cycle %0d want %0d", rel_cyc, acc_cyc + 2); else npass++;
    nchk++; if (in_ready !== 1'b0 || done !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL basic_final: got rdy=%b done=%b cpu_rst=%b want 0 1 0", in_ready, done, cpu_reset); else npass++;
  endtask

  task automatic test_zero();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00};
    do_reset();
    send_seq(s, 0);
    repeat (3) @(negedge clk);
    nchk++; if (wa_q.size() !== 0) $display("FAIL zero_nwrites: got %0d want 0", wa_q.size()); else npass++;
    nchk++; if (done_cyc !== acc_cyc + 1) $display("FAIL zero_done_time: got cycle %0d want %0d", done_cyc, acc_cyc + 1); else npass++;
    nchk++; if (rel_cyc !== acc_cyc + 1) $display("FAIL zero_release_time: got cycle %0d want %0d", rel_cyc, acc_cyc + 1); else npass++;
    nchk++; if (cpu_reset !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) $display("FAIL zero_final: got cpu_rst=%b done=%b rdy=%b want 0 1 0", cpu_reset, done, in_ready); else npass++;
  endtask

  task automatic test_overflow();
    logic [7:0] s[$];
    int bad;
    s = '{8'h01, 8'h01};
    do_reset();
    send_seq(s, 0);
    bad = 0;
    in_data  = 8'h77;
    in_valid = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (err !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    nchk++; if (bad !== 0) $display("FAIL ovf_hold: %0d bad cycles, last err=%b rdy=%b cpu_rst=%b want 1 0 1", bad, err, in_ready, cpu_reset); else npass++;
    nchk++; if (wa_q.size() !== 0 || done !== 1'b0) $display("FAIL ovf_no_write: got writes=%0d done=%b want 0 0", wa_q.size(), done); else npass++;
  endtask

  task automatic test_gaps();
    logic [7:0] s[$];
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    do_reset();
    send_seq(s, 5);
    repeat (4) @(negedge clk);
    nchk++; if (wa_q.size() !== 2) $display("FAIL gap_nwrites: got %0d want 2", wa_q.size()); else npass++;
    if (wa_q.size() == 2) begin
      nchk++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h12345678) $display("FAIL gap_w0: got %h %h want 00 12345678", wa_q[0], wd_q[0]); else npass++;
      nchk++; if (wa_q[1] !== 8'h01 || wd_q[1] !== 32'hABCDEF01) $display("FAIL gap_w1: got %h %h want 01 abcdef01", wa_q[1], wd_q[1]); else npass++;
    end
    nchk++; if (word_cnt !== 9'd2) $display("FAIL gap_word_cnt: got %0d want 2", word_cnt); else npass++;
    nchk++; if (rel_cyc !== acc_cyc + 2 || done_cyc !== acc_cyc + 2) $display("FAIL gap_release_time: got rel %0d done %0d want %0d", rel_cyc, done_cyc, acc_cyc + 2); else npass++;
  endtask

  task automatic test_abort();
    logic [7:0] s1[$];
    logic [7:0] s2[$];
    s1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
    s2 = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    send_seq(s1, 0);
    do_reset();
    nchk++; if (cpu_reset !== 1'b1 || word_cnt !== 9'd0 || in_ready !== 1'b1) $display("FAIL abort_reset: got cpu_rst=%b cnt=%0d rdy=%b want 1 0 1", cpu_reset, word_cnt, in_ready); else npass++;
    send_seq(s2, 0);
    repeat (4) @(negedge clk);
    nchk++; if (wa_q.size() !== 1) $display("FAIL abort_nwrites: got %0d want 1", wa_q.size()); else npass++;
    if (wa_q.size() == 1) begin
      nchk++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'hDEADBEEF) $display("FAIL abort_w0: got %h %h want 00 deadbeef", wa_q[0], wd_q[0]); else npass++;
    end
    nchk++; if (word_cnt !== 9'd1 || done !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL abort_final: got cnt=%0d done=%b cpu_rst=%b want 1 1 0", word_cnt, done, cpu_reset); else npass++;
  endtask

  task automatic test_full();
    logic [7:0]  s[$];
    logic [31:0] w;
    int bad;
    s = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(~i), 8'(i + 3), 8'h5A};
      s.push_back(w[31:24]);
      s.push_back(w[23:16]);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
    end
    do_reset();
    send_seq(s, 0);
    repeat (4) @(negedge clk);
    nchk++; if (wa_q.size() !== 256) $display("FAIL full_nwrites: got %0d want 256", wa_q.size()); else npass++;
    if (wa_q.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        w = {8'(i), 8'(~i), 8'(i + 3), 8'h5A};
        if (wa_q[i] !== 8'(i) || wd_q[i] !== w) bad++;
      end
      nchk++; if (bad !== 0) $display("FAIL full_contents: %0d wrong writes, want 0", bad); else npass++;
      nchk++; if (wa_q[255] !== 8'hFF) $display("FAIL full_last_addr: got %h want ff", wa_q[255]); else npass++;
    end
    nchk++; if (word_cnt !== 9'd256 || done !== 1'b1 || err !== 1'b0) $display("FAIL full_final: got cnt=%0d done=%b err=%b want 256 1 0", word_cnt, done, err); else npass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_gaps();
    test_abort();
    test_full();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
